// File: rtl/uart_header_rx_pkg.sv
// Shared constants and byte-FSM encoding for the UART header receiver.
package uart_header_rx_pkg;

  localparam int HEADER_BYTES = 80;
  localparam int HEADER_BITS  = 640;
  localparam int CLKS_PER_BIT_115200 = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_header_rx_if.sv
// Header output bundle with valid/ack handshake and status pulses.
interface uart_header_rx_if;
  import uart_header_rx_pkg::*;

  logic [HEADER_BITS-1:0] header_out;
  logic                   header_valid;
  logic                   header_ack;
  logic [6:0]             byte_count;
  logic                   frame_error;
  logic                   overrun;

  modport master (
    output header_out,
    output header_valid,
    output byte_count,
    output frame_error,
    output overrun,
    input  header_ack
  );

  modport slave (
    input  header_out,
    input  header_valid,
    input  byte_count,
    input  frame_error,
    input  overrun,
    output header_ack
  );

endinterface

// File: rtl/uart_header_rx_byte.sv
// 8N1 byte receiver: synchronizer, baud/bit counters and byte FSM.
module uart_rx_byte
  import uart_header_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       frame_err_strobe,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    sh, sh_n;
  logic          rx_meta, rx_sync;
  logic          armed, armed_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      rx_meta <= rx;
      rx_sync <= rx_meta;
      armed   <= armed_n;
    end
  end

  // armed blocks start detection until the line has been seen idle high
  always_comb begin
    state_n          = state;
    cnt_n            = cnt + CW'(1);
    bit_n            = bit_idx;
    sh_n             = sh;
    armed_n          = armed | rx_sync;
    byte_strobe      = 1'b0;
    frame_err_strobe = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (armed && !rx_sync)
          state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          bit_n = '0;
          if (rx_sync) begin
            frame_err_strobe = 1'b1;
            state_n          = IDLE;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_sync, sh[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_sync) begin
            byte_strobe = 1'b1;
          end else begin
            frame_err_strobe = 1'b1;
            armed_n          = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_data = sh;
  assign busy      = (state != IDLE);

endmodule

// File: rtl/uart_header_rx.sv
// Assembles 80 UART bytes into a 640-bit header with valid/ack handshake.
// Optional trailing XOR checksum byte: define UART_HEADER_CHECKSUM_EN.
module uart_header_rx
  import uart_header_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  uart_header_rx_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [6:0] LAST = 7'(HEADER_BYTES);

  logic [7:0]             bdata;
  logic                   bstb, ferr, rx_busy;
  logic [HEADER_BITS-1:0] hdr;
  logic                   valid, fe, ov, ack_now;
  logic [6:0]             cnt, wr_idx;
  logic [TW-1:0]          tmo;
`ifdef UART_HEADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock            (clock),
    .reset            (reset),
    .rx               (rx),
    .byte_data        (bdata),
    .byte_strobe      (bstb),
    .frame_err_strobe (ferr),
    .busy             (rx_busy)
  );

  // an ack on the completing cycle makes the new byte slot 0
  always_comb begin
    ack_now = valid && bus.header_ack;
    wr_idx  = ack_now ? 7'd0 : cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      tmo   <= '0;
      fe    <= 1'b0;
      ov    <= 1'b0;
`ifdef UART_HEADER_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      fe <= 1'b0;
      ov <= 1'b0;
      if (rx_busy || cnt == 7'd0 || valid) begin
        tmo <= '0;
      end else if (tmo == TMO_LAST) begin
        tmo <= '0;
        if (cnt < LAST)
          cnt <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end
      if (ack_now) begin
        valid <= 1'b0;
        cnt   <= '0;
      end
      if (ferr) begin
        fe <= 1'b1;
        if (!valid || ack_now)
          cnt <= '0;
      end else if (bstb) begin
        if (valid && !ack_now) begin
          ov <= 1'b1;
`ifdef UART_HEADER_CHECKSUM_EN
        end else if (wr_idx == LAST) begin
          if (bdata == csum) begin
            valid <= 1'b1;
          end else begin
            fe  <= 1'b1;
            cnt <= '0;
          end
`endif
        end else begin
          hdr[HEADER_BITS-1-8*int'(wr_idx) -: 8] <= bdata;
          cnt <= wr_idx + 7'd1;
`ifdef UART_HEADER_CHECKSUM_EN
          csum <= (wr_idx == 7'd0) ? bdata : (csum ^ bdata);
`else
          if (wr_idx == LAST - 7'd1)
            valid <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.header_out   = hdr;
  assign bus.header_valid = valid;
  assign bus.byte_count   = cnt;
  assign bus.frame_error  = fe;
  assign bus.overrun      = ov;

endmodule

// File: tb/tb_uart_header_rx.sv
// Scoreboard bench for uart_header_rx with shortened baud and timeout.
module tb_uart_header_rx;
  import uart_header_rx_pkg::*;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int TMO  = 300;
  localparam int EV_HDR = 0;
  localparam int EV_FE  = 1;
  localparam int EV_OV  = 2;

  typedef struct {
    int               kind;
    logic [639:0]     hdr;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  logic rx;
  int   errors = 0;
  int   checks = 0;
  ev_t  q[$];

  uart_header_rx_if bus();

  uart_header_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  localparam logic [639:0] GENESIS = {
    32'h01000000,
    256'h0,
    256'h3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };

  task automatic chk(input string name, input logic [639:0] act,
                     input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int kind, input logic [639:0] h);
    ev_t e;
    e.kind = kind;
    e.hdr  = h;
    q.push_back(e);
  endtask

  function automatic logic [639:0] mk(input int seed);
    logic [639:0] h = '0;
    for (int i = 0; i < 80; i++)
      h[639-8*i -: 8] = 8'(i * 7 + seed);
    return h;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input bit lat);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    if (lat) begin
      tick(HALF + 2);
      chk("valid_before_stop_sample", 640'(bus.header_valid), 640'(0));
      tick(1);
      chk("valid_latency", 640'(bus.header_valid), 640'(1));
      tick(CPB - HALF - 3);
    end else begin
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic send_hdr(input logic [639:0] h);
    logic [7:0] x = '0;
    for (int i = 0; i < 80; i++) begin
      x ^= h[639-8*i -: 8];
`ifdef UART_HEADER_CHECKSUM_EN
      send_byte(h[639-8*i -: 8], 1'b1, 1'b0);
`else
      send_byte(h[639-8*i -: 8], 1'b1, i == 79);
`endif
    end
`ifdef UART_HEADER_CHECKSUM_EN
    send_byte(x, 1'b1, 1'b1);
`endif
  endtask

  task automatic ack();
    bus.header_ack = 1'b1;
    tick(1);
    bus.header_ack = 1'b0;
    chk("ack_valid", 640'(bus.header_valid), 640'(0));
    chk("ack_count", 640'(bus.byte_count), 640'(0));
  endtask

  initial begin
    logic hv_q = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        logic hit;
        hit = (k == EV_HDR) ? (bus.header_valid && !hv_q) :
              (k == EV_FE)  ? bus.frame_error : bus.overrun;
        if (hit) begin
          if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
          end else begin
            e = q.pop_front();
            chk("event_kind", 640'(k), 640'(e.kind));
            if (k == EV_HDR) begin
              chk("header_out", bus.header_out, e.hdr);
              chk("header_count", 640'(bus.byte_count), 640'(80));
            end
          end
        end
      end
      hv_q = bus.header_valid;
    end
  end

  initial begin
    logic [639:0] h2, h3;
    h2 = mk(3);
    h3 = mk(8'hA0);
    reset = 1'b1;
    rx = 1'b0;
    bus.header_ack = 1'b0;
    tick(5);
    chk("rst_header", bus.header_out, 640'(0));
    chk("rst_valid", 640'(bus.header_valid), 640'(0));
    chk("rst_count", 640'(bus.byte_count), 640'(0));
    chk("rst_fe", 640'(bus.frame_error), 640'(0));
    chk("rst_ov", 640'(bus.overrun), 640'(0));
    reset = 1'b0;
    tick(20);
    chk("low_after_rst", 640'(bus.byte_count), 640'(0));
    rx = 1'b1;
    tick(10);

    push(EV_HDR, GENESIS);
    send_hdr(GENESIS);
    chk("genesis_count", 640'(bus.byte_count), 640'(80));

    push(EV_OV, '0);
    send_byte(8'hAA, 1'b1, 1'b0);
    tick(2);
    chk("overrun_hold", bus.header_out, GENESIS);
    chk("overrun_valid", 640'(bus.header_valid), 640'(1));
    ack();

    for (int i = 0; i < 5; i++)
      send_byte(8'(8'h50 + i), 1'b1, 1'b0);
    chk("five_count", 640'(bus.byte_count), 640'(5));
    push(EV_FE, '0);
    send_byte(8'h33, 1'b0, 1'b0);
    tick(2 * CPB);
    chk("bad_stop_count", 640'(bus.byte_count), 640'(0));
    push(EV_HDR, h2);
    send_hdr(h2);
    ack();

    push(EV_FE, '0);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(3 * CPB);
    chk("glitch_count", 640'(bus.byte_count), 640'(0));
    chk("glitch_valid", 640'(bus.header_valid), 640'(0));

    for (int i = 0; i < 10; i++)
      send_byte(8'(8'hC0 + i), 1'b1, 1'b0);
    chk("ten_count", 640'(bus.byte_count), 640'(10));
    tick(TMO - 20);
    chk("pre_timeout", 640'(bus.byte_count), 640'(10));
    tick(30);
    chk("timeout_count", 640'(bus.byte_count), 640'(0));
    chk("timeout_valid", 640'(bus.header_valid), 640'(0));

    for (int i = 0; i < 39; i++)
      send_byte(8'(i), 1'b1, 1'b0);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(CPB);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rx = 1'b1;
    chk("mid_rst_header", bus.header_out, 640'(0));
    chk("mid_rst_count", 640'(bus.byte_count), 640'(0));
    chk("mid_rst_valid", 640'(bus.header_valid), 640'(0));
    chk("mid_rst_fe", 640'(bus.frame_error), 640'(0));
    chk("mid_rst_ov", 640'(bus.overrun), 640'(0));
    tick(4 * CPB);
    push(EV_HDR, h3);
    send_hdr(h3);
    ack();

    tick(20);
    chk("queue_empty", 640'(q.size()), 640'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
